pico_ctrl: RTL and testbench
============================

Name: pico_ctrl

Overview:
- Fetch/decode/sequencer stage directly upstream of the picoMips ALU.
- Holds the program counter, addresses an external combinational program ROM and decodes each instruction.
- Drives the ALU control/data inputs (WE, UseMul, UseA, DataA, DataB) and takes ACC back for branches and output.
- Provides valid/ready handshakes for the external switch input and the result output port.

Parameters:
- PCW, 5, program counter / ROM address width.
- IW, 16, instruction width; opcode = Instr[IW-1:IW-3], immediate = Instr[7:0].

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Instr  input  IW  instruction word read from ROM at InstrAddr (combinational ROM).
- InstrAddr  output  PCW  program counter.
- ACC  input  8  ALU accumulator (fed back).
- WE  output  1  ALU accumulator write enable.
- UseMul  output  1  ALU multiply select.
- UseA  output  1  ALU use-ACC select.
- DataA  output  8  ALU operand A; always equals ACC.
- DataB  output  8  ALU operand B.
- InData  input  8  switch input data.
- InValid  input  1  InData valid.
- InReady  output  1  input accepted this cycle.
- OutData  output  8  registered result.
- OutValid  output  1  OutData valid.
- OutReady  input  1  consumer accepts OutData.

Behaviour:
- Reset (asynchronous, active-low):
  - PC=0, state=RUN, OutValid=0, OutData=0.
  - Combinational outputs decode from state RUN.
- States: RUN, WAIT_OUT, HALT.
- Opcodes (decoded in RUN):
  - 0 NOP: no ALU write; PC+1.
  - 1 LDI: WE=1, UseA=0, UseMul=0, DataB=imm; PC+1.
  - 2 ADDI: WE=1, UseA=1, UseMul=0, DataB=imm; PC+1.
  - 3 MULI: WE=1, UseA=1, UseMul=1, DataB=imm; PC+1.
  - 4 LDIN: InReady=1, DataB=InData, UseA=0, UseMul=0, WE=InValid. PC+1 only when InValid=1; otherwise PC held (stall, re-decode next cycle).
  - 5 OUT: OutData<=ACC, OutValid<=1, PC held, next state WAIT_OUT.
  - 6 BNZ: if ACC!=0, PC<=imm[PCW-1:0], else PC+1. No ALU write.
  - 7: see Optional Feature.
- WAIT_OUT:
  - WE=0, InReady=0, PC held.
  - When OutReady=1: OutValid<=0, PC+1, next state RUN. Exactly one transfer per OUT.
  - OutData is stable while OutValid=1.
- Outputs outside a decoded opcode:
  - When not decoding a write opcode: WE=0, UseA=0, UseMul=0, DataB=0.
  - InReady=0 except LDIN in RUN.
- PC increment wraps 2^PCW-1 -> 0. A branch target above the ROM range is truncated to PCW bits.
- ACC sampled for BNZ is the value before any write that cycle; BNZ never writes, so there is no hazard.
- Reset asserted mid-handshake: OutValid drops immediately and any pending transfer is abandoned.

Optional Feature:
- Macro: PICO_HALT_OPCODE_EN.
- Defined: opcode 7 = HALT.
  - Next state HALT; PC frozen; WE=0, InReady=0, OutValid=0.
  - Exit only by reset.
- Undefined: opcode 7 behaves as NOP (PC+1); state HALT is unreachable and not implemented.

Test Plan:
- Reset, ROM {LDI 0x05, ADDI 0x03, NOP}:
  - Cycle 0: WE=1, UseA=0, DataB=0x05.
  - Cycle 1: WE=1, UseA=1, DataB=0x03.
  - Cycle 2: WE=0. InstrAddr steps 0,1,2.
- LDIN at PC=4 with InValid low 3 cycles, then InData=0xA7, InValid=1:
  - InstrAddr stays 4 with WE=0 for 3 cycles.
  - Then WE=1, DataB=0xA7, InReady=1; PC=5 next cycle.
- OUT with ACC=0x3C, OutReady low 2 cycles then high:
  - OutValid=1 and OutData=0x3C for 3 cycles; PC held.
  - PC+1 and OutValid=0 the cycle after OutReady.
- BNZ imm=0x02 at PC=9:
  - ACC=0x01: next InstrAddr=2.
  - ACC=0x00: next InstrAddr=10.
  - MULI 0x40: UseMul=1, UseA=1, WE=1.
- PC wrap and reset mid-handshake:
  - NOP at PC=31 -> InstrAddr 0.
  - Assert nReset low during WAIT_OUT: OutValid=0 and InstrAddr=0 immediately, without a clock edge.
- With PICO_HALT_OPCODE_EN, opcode 7 at PC=6: PC frozen at 6 and WE=0 for 10 cycles. Without the macro: PC=7 next cycle.

Source files
------------

// File: rtl/pico_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pico_ctrl : picoMips fetch/decode/sequencer feeding the ALU, with switch    |
// |             input and result output valid/ready handshakes.                 |
// | Option    : PICO_HALT_OPCODE_EN turns opcode 7 into HALT (else NOP).        |
// | Revision  : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module pico_ctrl #(
   parameter int PCW = 5,
   parameter int IW  = 16
) (
   input  logic           Clock,
   input  logic           nReset,
   input  logic [IW-1:0]  Instr,
   output logic [PCW-1:0] InstrAddr,
   input  logic [7:0]     ACC,
   output logic           WE,
   output logic           UseMul,
   output logic           UseA,
   output logic [7:0]     DataA,
   output logic [7:0]     DataB,
   input  logic [7:0]     InData,
   input  logic           InValid,
   output logic           InReady,
   output logic [7:0]     OutData,
   output logic           OutValid,
   input  logic           OutReady
);

   localparam logic [2:0] c_OP_NOP  = 3'd0;
   localparam logic [2:0] c_OP_LDI  = 3'd1;
   localparam logic [2:0] c_OP_ADDI = 3'd2;
   localparam logic [2:0] c_OP_MULI = 3'd3;
   localparam logic [2:0] c_OP_LDIN = 3'd4;
   localparam logic [2:0] c_OP_OUT  = 3'd5;
   localparam logic [2:0] c_OP_BNZ  = 3'd6;
   localparam logic [2:0] c_OP_EXT  = 3'd7;

`ifdef PICO_HALT_OPCODE_EN
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_OUT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_OUT = 2'd1
   } state_t;
`endif

   state_t         r_state;
   logic [PCW-1:0] r_pc;
   logic [7:0]     r_out_data;
   logic           r_out_valid;

   logic [2:0]     w_opcode;
   logic [7:0]     w_imm;
   logic [PCW-1:0] w_pc_inc;
   logic [PCW-1:0] w_br_target;
   logic           w_unused;

   assign w_opcode    = Instr[IW-1 -: 3];
   assign w_imm       = Instr[7:0];
   assign w_pc_inc    = r_pc + 1'b1;
   assign w_br_target = PCW'(w_imm);
   assign w_unused    = ^Instr[IW-4:8];

   assign InstrAddr = r_pc;
   assign DataA     = ACC;
   assign OutData   = r_out_data;
   assign OutValid  = r_out_valid;

   // ALU controls are decoded straight from the ROM word in RUN only.
   always_comb begin
      WE      = 1'b0;
      UseA    = 1'b0;
      UseMul  = 1'b0;
      DataB   = 8'h00;
      InReady = 1'b0;
      if (r_state == ST_RUN) begin
         case (w_opcode)
            c_OP_LDI: begin
               WE    = 1'b1;
               DataB = w_imm;
            end
            c_OP_ADDI: begin
               WE    = 1'b1;
               UseA  = 1'b1;
               DataB = w_imm;
            end
            c_OP_MULI: begin
               WE     = 1'b1;
               UseA   = 1'b1;
               UseMul = 1'b1;
               DataB  = w_imm;
            end
            c_OP_LDIN: begin
               InReady = 1'b1;
               WE      = InValid;
               DataB   = InData;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state     <= ST_RUN;
         r_pc        <= '0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               case (w_opcode)
                  c_OP_NOP, c_OP_LDI, c_OP_ADDI, c_OP_MULI: r_pc <= w_pc_inc;
                  c_OP_LDIN: begin
                     if (InValid) r_pc <= w_pc_inc;
                  end
                  c_OP_OUT: begin
                     r_out_data  <= ACC;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_WAIT_OUT;
                  end
                  c_OP_BNZ: begin
                     r_pc <= (ACC != 8'h00) ? w_br_target : w_pc_inc;
                  end
                  c_OP_EXT: begin
`ifdef PICO_HALT_OPCODE_EN
                     r_out_valid <= 1'b0;
                     r_state     <= ST_HALT;
`else
                     r_pc <= w_pc_inc;
`endif
                  end
                  default: ;
               endcase
            end
            ST_WAIT_OUT: begin
               // OutData stays frozen until the single transfer completes.
               if (OutReady) begin
                  r_out_valid <= 1'b0;
                  r_pc        <= w_pc_inc;
                  r_state     <= ST_RUN;
               end
            end
`ifdef PICO_HALT_OPCODE_EN
            ST_HALT: begin
               r_out_valid <= 1'b0;
            end
`endif
            default: r_state <= ST_RUN;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pico_ctrl.sv
`default_nettype none
// Testbench for pico_ctrl: directed scenarios plus randomized programs checked
// against a behavioural instruction-level model.
module tb_pico_ctrl;

   localparam int PCW = 5;
   localparam int IW  = 16;
   localparam int ROMN = 1 << PCW;

   logic           Clock;
   logic           nReset;
   logic [IW-1:0]  Instr;
   logic [PCW-1:0] InstrAddr;
   logic [7:0]     ACC;
   logic           WE, UseMul, UseA;
   logic [7:0]     DataA, DataB;
   logic [7:0]     InData;
   logic           InValid;
   logic           InReady;
   logic [7:0]     OutData;
   logic           OutValid;
   logic           OutReady;

   logic [IW-1:0]  rom [0:ROMN-1];
   int n_checks = 0;
   int n_err    = 0;

   assign Instr = rom[InstrAddr];

   pico_ctrl #(.PCW(PCW), .IW(IW)) dut (
      .Clock(Clock), .nReset(nReset), .Instr(Instr), .InstrAddr(InstrAddr),
      .ACC(ACC), .WE(WE), .UseMul(UseMul), .UseA(UseA), .DataA(DataA),
      .DataB(DataB), .InData(InData), .InValid(InValid), .InReady(InReady),
      .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [IW-1:0] enc(input logic [2:0] op, input logic [7:0] imm);
      return {op, 5'b00000, imm};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < ROMN; i++) rom[i] = enc(3'd0, 8'h00);
   endtask

   task automatic do_reset();
      InValid = 1'b0; OutReady = 1'b0; ACC = 8'h00; InData = 8'h00;
      @(posedge Clock);
      #1 nReset = 1'b0;
      #3 nReset = 1'b1;
      #2;
   endtask

   task automatic test_reset();
      clear_rom();
      rom[0] = enc(3'd1, 8'h5A);
      InValid = 1'b0; OutReady = 1'b0; ACC = 8'h00; InData = 8'h00;
      nReset = 1'b1;
      #1 nReset = 1'b0;
      #2;
      n_checks++; if (InstrAddr !== 5'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", InstrAddr); end
      n_checks++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %0b want 0", OutValid); end
      n_checks++; if (OutData !== 8'h00) begin n_err++; $display("FAIL reset_odata: got %0h want 00", OutData); end
      n_checks++; if (WE !== 1'b1 || DataB !== 8'h5A) begin n_err++; $display("FAIL reset_decode: got we=%0b db=%0h want we=1 db=5a", WE, DataB); end
      nReset = 1'b1;
   endtask

   task automatic test_basic();
      clear_rom();
      rom[0] = enc(3'd1, 8'h05);
      rom[1] = enc(3'd2, 8'h03);
      do_reset();
      n_checks++; if ({WE, UseA, UseMul, DataB} !== {3'b100, 8'h05}) begin n_err++; $display("FAIL basic_c0: got we=%0b ua=%0b um=%0b db=%0h want 1 0 0 05", WE, UseA, UseMul, DataB); end
      n_checks++; if (InstrAddr !== 5'd0) begin n_err++; $display("FAIL basic_pc0: got %0d want 0", InstrAddr); end
      tick();
      n_checks++; if ({WE, UseA, UseMul, DataB} !== {3'b110, 8'h03}) begin n_err++; $display("FAIL basic_c1: got we=%0b ua=%0b um=%0b db=%0h want 1 1 0 03", WE, UseA, UseMul, DataB); end
      n_checks++; if (InstrAddr !== 5'd1) begin n_err++; $display("FAIL basic_pc1: got %0d want 1", InstrAddr); end
      tick();
      n_checks++; if ({WE, UseA, UseMul, DataB, InReady} !== {3'b000, 8'h00, 1'b0}) begin n_err++; $display("FAIL basic_c2: got we=%0b ua=%0b db=%0h ir=%0b want all 0", WE, UseA, DataB, InReady); end
      n_checks++; if (InstrAddr !== 5'd2) begin n_err++; $display("FAIL basic_pc2: got %0d want 2", InstrAddr); end
   endtask

   task automatic test_ldin();
      clear_rom();
      rom[4] = enc(3'd4, 8'hFF);
      do_reset();
      InData = 8'h3E;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (InstrAddr !== 5'd4 || WE !== 1'b0 || InReady !== 1'b1) begin n_err++; $display("FAIL ldin_stall%0d: got pc=%0d we=%0b ir=%0b want 4 0 1", i, InstrAddr, WE, InReady); end
         tick();
      end
      InData = 8'hA7; InValid = 1'b1;
      #1;
      n_checks++; if ({WE, UseA, UseMul, InReady, DataB} !== {4'b1001, 8'hA7}) begin n_err++; $display("FAIL ldin_accept: got we=%0b ua=%0b um=%0b ir=%0b db=%0h want 1 0 0 1 a7", WE, UseA, UseMul, InReady, DataB); end
      tick();
      InValid = 1'b0;
      #1;
      n_checks++; if (InstrAddr !== 5'd5 || InReady !== 1'b0) begin n_err++; $display("FAIL ldin_next: got pc=%0d ir=%0b want 5 0", InstrAddr, InReady); end
   endtask

   task automatic test_out();
      clear_rom();
      rom[5] = enc(3'd5, 8'h00);
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      ACC = 8'h3C;
      #1;
      n_checks++; if (WE !== 1'b0 || OutValid !== 1'b0) begin n_err++; $display("FAIL out_decode: got we=%0b ov=%0b want 0 0", WE, OutValid); end
      tick();
      ACC = 8'h99;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) OutReady = 1'b1;
         #1;
         n_checks++; if (OutValid !== 1'b1 || OutData !== 8'h3C || InstrAddr !== 5'd5) begin n_err++; $display("FAIL out_wait%0d: got ov=%0b od=%0h pc=%0d want 1 3c 5", i, OutValid, OutData, InstrAddr); end
         n_checks++; if (WE !== 1'b0 || InReady !== 1'b0) begin n_err++; $display("FAIL out_wait_ctl%0d: got we=%0b ir=%0b want 0 0", i, WE, InReady); end
         tick();
      end
      OutReady = 1'b0;
      #1;
      n_checks++; if (OutValid !== 1'b0 || InstrAddr !== 5'd6) begin n_err++; $display("FAIL out_done: got ov=%0b pc=%0d want 0 6", OutValid, InstrAddr); end
      tick();
      n_checks++; if (OutValid !== 1'b0 || InstrAddr !== 5'd7) begin n_err++; $display("FAIL out_once: got ov=%0b pc=%0d want 0 7", OutValid, InstrAddr); end
   endtask

   task automatic test_bnz();
      logic [7:0] accs [0:2];
      logic [7:0] imms [0:2];
      logic [4:0] want [0:2];
      accs[0] = 8'h01; imms[0] = 8'h02; want[0] = 5'd2;
      accs[1] = 8'h00; imms[1] = 8'h02; want[1] = 5'd10;
      accs[2] = 8'h80; imms[2] = 8'hE3; want[2] = 5'd3;
      for (int k = 0; k < 3; k++) begin
         clear_rom();
         rom[9] = enc(3'd6, imms[k]);
         do_reset();
         for (int i = 0; i < 9; i++) tick();
         ACC = accs[k];
         #1;
         n_checks++; if (WE !== 1'b0) begin n_err++; $display("FAIL bnz_we%0d: got %0b want 0", k, WE); end
         tick();
         n_checks++; if (InstrAddr !== want[k]) begin n_err++; $display("FAIL bnz_target%0d: got %0d want %0d", k, InstrAddr, want[k]); end
      end
   endtask

   task automatic test_muli();
      clear_rom();
      rom[0] = enc(3'd3, 8'h40);
      do_reset();
      ACC = 8'hC5;
      #1;
      n_checks++; if ({WE, UseA, UseMul, DataB} !== {3'b111, 8'h40}) begin n_err++; $display("FAIL muli: got we=%0b ua=%0b um=%0b db=%0h want 1 1 1 40", WE, UseA, UseMul, DataB); end
      n_checks++; if (DataA !== 8'hC5) begin n_err++; $display("FAIL dataa: got %0h want c5", DataA); end
   endtask

   task automatic test_wrap();
      clear_rom();
      do_reset();
      for (int i = 0; i < 31; i++) tick();
      n_checks++; if (InstrAddr !== 5'd31) begin n_err++; $display("FAIL wrap_pre: got %0d want 31", InstrAddr); end
      tick();
      n_checks++; if (InstrAddr !== 5'd0) begin n_err++; $display("FAIL wrap: got %0d want 0", InstrAddr); end
   endtask

   task automatic test_reset_mid_handshake();
      clear_rom();
      rom[2] = enc(3'd5, 8'h00);
      do_reset();
      tick(); tick();
      ACC = 8'h55;
      tick();
      n_checks++; if (OutValid !== 1'b1 || OutData !== 8'h55) begin n_err++; $display("FAIL midrst_pre: got ov=%0b od=%0h want 1 55", OutValid, OutData); end
      #1 nReset = 1'b0;
      #1;
      n_checks++; if (OutValid !== 1'b0 || InstrAddr !== 5'd0) begin n_err++; $display("FAIL midrst: got ov=%0b pc=%0d want 0 0", OutValid, InstrAddr); end
      #2 nReset = 1'b1;
      #1;
      tick();
      n_checks++; if (InstrAddr !== 5'd1 || OutValid !== 1'b0) begin n_err++; $display("FAIL midrst_after: got pc=%0d ov=%0b want 1 0", InstrAddr, OutValid); end
   endtask

   task automatic test_opcode7();
      clear_rom();
      rom[6] = enc(3'd7, 8'h00);
      rom[7] = enc(3'd1, 8'h11);
      do_reset();
      for (int i = 0; i < 6; i++) tick();
      InValid = 1'b1;
      tick();
`ifdef PICO_HALT_OPCODE_EN
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (InstrAddr !== 5'd6 || WE !== 1'b0 || InReady !== 1'b0 || OutValid !== 1'b0) begin n_err++; $display("FAIL halt%0d: got pc=%0d we=%0b ir=%0b ov=%0b want 6 0 0 0", i, InstrAddr, WE, InReady, OutValid); end
         tick();
      end
`else
      n_checks++; if (InstrAddr !== 5'd7 || WE !== 1'b1) begin n_err++; $display("FAIL op7_nop: got pc=%0d we=%0b want 7 1", InstrAddr, WE); end
`endif
      InValid = 1'b0;
   endtask

   task automatic test_random();
      int m_pc, m_wait, m_halt, m_ov;
      logic [7:0] m_od;
      logic [2:0] op;
      logic [7:0] imm;
      logic e_we, e_ua, e_um, e_ir;
      logic [7:0] e_db;
      for (int i = 0; i < ROMN; i++) begin
`ifdef PICO_HALT_OPCODE_EN
         op = 3'($urandom_range(0, 6));
`else
         op = 3'($urandom_range(0, 7));
`endif
         rom[i] = enc(op, 8'($urandom));
      end
      do_reset();
      m_pc = 0; m_wait = 0; m_halt = 0; m_ov = 0; m_od = 8'h00;
      for (int c = 0; c < 600; c++) begin
         ACC      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         InData   = 8'($urandom);
         InValid  = 1'($urandom);
         OutReady = 1'($urandom);
         #1;
         op  = rom[m_pc][IW-1 -: 3];
         imm = rom[m_pc][7:0];
         e_we = 0; e_ua = 0; e_um = 0; e_ir = 0; e_db = 8'h00;
         if (m_wait == 0 && m_halt == 0) begin
            if (op == 3'd1 || op == 3'd2 || op == 3'd3) begin
               e_we = 1; e_db = imm; e_ua = (op != 3'd1); e_um = (op == 3'd3);
            end else if (op == 3'd4) begin
               e_ir = 1; e_we = InValid; e_db = InData;
            end
         end
         n_checks++; if ({WE, UseA, UseMul, InReady, DataB} !== {e_we, e_ua, e_um, e_ir, e_db}) begin n_err++; $display("FAIL rnd_ctl c%0d: got %0b%0b%0b%0b db=%0h want %0b%0b%0b%0b db=%0h", c, WE, UseA, UseMul, InReady, DataB, e_we, e_ua, e_um, e_ir, e_db); end
         n_checks++; if (InstrAddr !== 5'(m_pc) || DataA !== ACC) begin n_err++; $display("FAIL rnd_pc c%0d: got pc=%0d da=%0h want %0d %0h", c, InstrAddr, DataA, m_pc, ACC); end
         n_checks++; if (OutValid !== 1'(m_ov) || (m_ov == 1 && OutData !== m_od)) begin n_err++; $display("FAIL rnd_out c%0d: got ov=%0b od=%0h want %0b %0h", c, OutValid, OutData, m_ov, m_od); end
         if (m_halt != 0) begin
         end else if (m_wait != 0) begin
            if (OutReady) begin m_ov = 0; m_wait = 0; m_pc = (m_pc + 1) % ROMN; end
         end else begin
            case (op)
               3'd4: if (InValid) m_pc = (m_pc + 1) % ROMN;
               3'd5: begin m_od = ACC; m_ov = 1; m_wait = 1; end
               3'd6: m_pc = (ACC != 0) ? (int'(imm) % ROMN) : (m_pc + 1) % ROMN;
`ifdef PICO_HALT_OPCODE_EN
               3'd7: m_halt = 1;
`endif
               default: m_pc = (m_pc + 1) % ROMN;
            endcase
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ldin();
      test_out();
      test_bnz();
      test_muli();
      test_wrap();
      test_reset_mid_handshake();
      test_opcode7();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
